// File: rtl/atomik_telemetry_tx.sv
// atomik_telemetry_tx: serialises each captured 32-bit core word as a 6-byte
// 8N1 UART frame (sync, 4 data bytes MSB first, XOR checksum). A one-word
// holding register absorbs the next word while a frame is on the wire; any
// further words are dropped and counted.
module atomik_telemetry_tx #(
    parameter int unsigned CLK_FREQ  = 94_500_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned DIV      = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        byte_idx;
    logic [31:0]       frame_word;
    logic [31:0]       hold_word;
    logic              hold_full;
    logic [7:0]        cur_byte;
    logic [7:0]        checksum;

    logic baud_tick;
    logic last_byte;
    logic frame_end;
    logic take;
    logic capture;
    logic drop;

    assign baud_tick = (baud_cnt == CNT_LAST);
    assign last_byte = (byte_idx == 3'd5);
    assign frame_end = (state == S_STOP) && last_byte && baud_tick;
    // The held word moves into the frame register either from idle or on
    // the final stop-bit edge, so consecutive frames run without a gap.
    assign take      = hold_full && ((state == S_IDLE) || frame_end);
    // A word arriving on the transfer edge reuses the slot being vacated.
    assign capture   = enable && data_valid && (!hold_full || take);
    assign drop      = enable && data_valid && hold_full && !take;

    assign checksum  = SYNC_BYTE ^ frame_word[31:24] ^ frame_word[23:16]
                     ^ frame_word[15:8] ^ frame_word[7:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: each serial bit lasts one full baud period.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        case (state)
            S_IDLE:  if (hold_full) state_nxt = S_START;
            S_START: if (baud_tick) state_nxt = S_DATA;
            S_DATA:  if (baud_tick && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP: begin
                if (baud_tick) begin
                    if (!last_byte || hold_full) state_nxt = S_START;
                    else                         state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte selection and line/status outputs decoded from the current state.
    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = frame_word[31:24];
            3'd2:    cur_byte = frame_word[23:16];
            3'd3:    cur_byte = frame_word[15:8];
            3'd4:    cur_byte = frame_word[7:0];
            default: cur_byte = checksum;
        endcase
        uart_tx    = 1'b1;
        busy       = (state != S_IDLE) || hold_full;
        frame_done = frame_end;
        case (state)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = cur_byte[bit_idx];
            default: uart_tx = 1'b1;
        endcase
    end

    // Baud timing, bit/byte indices, holding register and drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            frame_word <= '0;
            hold_word  <= '0;
            hold_full  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if ((state == S_IDLE) || baud_tick) baud_cnt <= '0;
            else                                baud_cnt <= baud_cnt + CNT_W'(1);

            if ((state == S_START) && baud_tick)     bit_idx <= '0;
            else if ((state == S_DATA) && baud_tick) bit_idx <= bit_idx + 3'd1;

            if (take) begin
                byte_idx   <= '0;
                frame_word <= hold_word;
            end else if ((state == S_STOP) && baud_tick && !last_byte) begin
                byte_idx <= byte_idx + 3'd1;
            end

            if (capture) begin
                hold_word <= data_in;
                hold_full <= 1'b1;
            end else if (take) begin
                hold_full <= 1'b0;
            end

            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_atomik_telemetry_tx.sv
// Directed bench for atomik_telemetry_tx with DIV = 4 (240-clock frames).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_atomik_telemetry_tx;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] data_in;
    logic        data_valid;
    logic        uart_tx;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rx_bytes [6];
    logic       dec_frame_ok;
    int         dec_done_cnt;
    logic       dec_done_last;

    atomik_telemetry_tx #(
        .CLK_FREQ  (400),
        .BAUD_RATE (100),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // One-cycle strobe; returns 1 ns after the edge that sampled it.
    task automatic strobe(input logic [31:0] w);
        data_in    = w;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    // Walks a frame from position n0 (cycles after the transfer edge) to 239,
    // sampling each bit at the centre of its 4-clock slot.
    task automatic decode_frame(input int n0);
        logic [59:0] bits;
        bits          = '1;
        dec_done_cnt  = 0;
        dec_done_last = 1'b0;
        for (int n = n0; n < 240; n++) begin
            if ((n % 4) == 2) bits[n / 4] = uart_tx;
            if (frame_done === 1'b1) dec_done_cnt++;
            if (n == 239) dec_done_last = frame_done;
            if (n < 239) step();
        end
        dec_frame_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (bits[k*10] !== 1'b0 || bits[k*10+9] !== 1'b1) dec_frame_ok = 1'b0;
            for (int i = 0; i < 8; i++) rx_bytes[k][i] = bits[k*10+1+i];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; data_valid = 1'b0; data_in = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAD};
        strobe(32'h1234_5678);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL single_no_early_start: got %b want 1", uart_tx); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_held: got %b want 1", busy); end
        step();
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL single_latency: got %b want 0", uart_tx); end
        decode_frame(0);
        n_cmp++; if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL single_framing: got %b want 1", dec_frame_ok); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_bytes[k] !== exp_b[k]) begin n_bad++; $display("FAIL single_byte%0d: got %h want %h", k, rx_bytes[k], exp_b[k]); end
        end
        n_cmp++; if (dec_done_cnt !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", dec_done_cnt); end
        n_cmp++; if (dec_done_last !== 1'b1) begin n_bad++; $display("FAIL single_done_at_240: got %b want 1", dec_done_last); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL single_done_width: got %b want 0", frame_done); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL single_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp1 [6];
        logic [7:0] exp2 [6];
        exp1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hA4};
        exp2 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'hA7};
        data_in = 32'h1; data_valid = 1'b1;
        step();                          // E0: word 1 captured
        data_in = 32'h2;
        step();                          // E1: transfer, word 2 captured
        data_in = 32'h3;
        step();                          // E2: word 3 dropped
        data_valid = 1'b0;
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL b2b_drop_cnt: got %0d want 1", drop_cnt); end
        decode_frame(1);
        n_cmp++; if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_framing1: got %b want 1", dec_frame_ok); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_bytes[k] !== exp1[k]) begin n_bad++; $display("FAIL b2b_f1_byte%0d: got %h want %h", k, rx_bytes[k], exp1[k]); end
        end
        n_cmp++; if (dec_done_last !== 1'b1) begin n_bad++; $display("FAIL b2b_done1: got %b want 1", dec_done_last); end
        step();
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL b2b_no_gap: got %b want 0", uart_tx); end
        decode_frame(0);
        n_cmp++; if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_framing2: got %b want 1", dec_frame_ok); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_bytes[k] !== exp2[k]) begin n_bad++; $display("FAIL b2b_f2_byte%0d: got %h want %h", k, rx_bytes[k], exp2[k]); end
        end
        n_cmp++; if (dec_done_cnt !== 1 || dec_done_last !== 1'b1) begin n_bad++; $display("FAIL b2b_done2: got cnt=%0d last=%b want 1/1", dec_done_cnt, dec_done_last); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL b2b_drop_final: got %0d want 1", drop_cnt); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_b [6];
        int         done_seen;
        int         waited;
        exp_b = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE1};
        apply_reset();
        strobe(32'h1122_3344);
        step();                          // transfer edge: frame starts
        fork
            decode_frame(0);
            begin
                data_in    = 32'h5555_5555;
                data_valid = 1'b1;
                repeat (301) step();
                data_valid = 1'b0;
            end
        join
        n_cmp++; if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL sat_framing: got %b want 1", dec_frame_ok); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_bytes[k] !== exp_b[k]) begin n_bad++; $display("FAIL sat_byte%0d: got %h want %h", k, rx_bytes[k], exp_b[k]); end
        end
        n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
        done_seen = 0;
        waited    = 0;
        while (busy === 1'b1 && waited < 1000) begin
            if (frame_done === 1'b1) done_seen++;
            step();
            waited++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_drain_timeout: busy=%b after %0d cycles want 0", busy, waited); end
        n_cmp++; if (done_seen !== 2) begin n_bad++; $display("FAIL sat_drain_frames: got %0d want 2", done_seen); end
        n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_drop_held: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_enable();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h87};
        apply_reset();
        enable     = 1'b0;
        data_in    = 32'hCAFE_BABE;
        data_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) data_valid = 1'b0;
            step();
            n_cmp++;
            if (uart_tx !== 1'b1 || busy !== 1'b0) begin
                n_bad++; $display("FAIL gate_idle_c%0d: got tx=%b busy=%b want 1/0", i, uart_tx, busy);
            end
        end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL gate_drop_cnt: got %0d want 0", drop_cnt); end
        enable = 1'b1;
        strobe(32'hDEAD_BEEF);
        step();
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL gate_start: got %b want 0", uart_tx); end
        decode_frame(0);
        n_cmp++; if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL gate_framing: got %b want 1", dec_frame_ok); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_bytes[k] !== exp_b[k]) begin n_bad++; $display("FAIL gate_byte%0d: got %h want %h", k, rx_bytes[k], exp_b[k]); end
        end
        step();
    endtask

    task automatic test_checksum();
        logic [31:0] ck_w [3];
        logic [7:0]  ck_e [3];
        ck_w = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hA500_0000};
        ck_e = '{8'hA5, 8'hA5, 8'h00};
        for (int t = 0; t < 3; t++) begin
            strobe(ck_w[t]);
            step();
            decode_frame(0);
            n_cmp++;
            if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL cksum%0d_framing: got %b want 1", t, dec_frame_ok); end
            n_cmp++;
            if (rx_bytes[1] !== ck_w[t][31:24]) begin n_bad++; $display("FAIL cksum%0d_msb: got %h want %h", t, rx_bytes[1], ck_w[t][31:24]); end
            n_cmp++;
            if (rx_bytes[5] !== ck_e[t]) begin n_bad++; $display("FAIL cksum%0d_byte: got %h want %h", t, rx_bytes[5], ck_e[t]); end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA5, 8'hCA, 8'hFE, 8'h00, 8'h01, 8'h90};
        apply_reset();
        strobe(32'h1234_5678);
        step();                          // frame position 0
        strobe(32'h0BAD_0001);           // fills holding register
        strobe(32'h0BAD_0002);           // dropped
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL rstmid_pre_drop: got %0d want 1", drop_cnt); end
        repeat (98) step();              // frame position 100
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rstmid_uart_tx: got %b want 1", uart_tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_drop_cnt: got %0d want 0", drop_cnt); end
        repeat (5) step();
        n_cmp++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_stays_idle: got tx=%b busy=%b want 1/0", uart_tx, busy); end
        strobe(32'hCAFE_0001);
        step();
        n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL rstmid_restart: got %b want 0", uart_tx); end
        decode_frame(0);
        n_cmp++; if (dec_frame_ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_framing: got %b want 1", dec_frame_ok); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (rx_bytes[k] !== exp_b[k]) begin n_bad++; $display("FAIL rstmid_byte%0d: got %h want %h", k, rx_bytes[k], exp_b[k]); end
        end
        n_cmp++; if (dec_done_cnt !== 1 || dec_done_last !== 1'b1) begin n_bad++; $display("FAIL rstmid_done: got cnt=%0d last=%b want 1/1", dec_done_cnt, dec_done_last); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_enable();
        test_checksum();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
